// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: size codes, FSM
// states, the latched request record and the access legality check.
package dmem_arb_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        id;
  } req_t;

  // Returns 1 when the access must be rejected: unknown size, unsigned
  // store, misalignment, or any byte of the access outside the window.
  // The offset is unsigned, so addresses below base wrap to huge values.
  function automatic logic access_err(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [2:0]  size,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] offset;
    logic        err;
    offset = addr - base;
    case (size)
      SZ_B, SZ_BU: err = (offset > (depth - 32'd1));
      SZ_H, SZ_HU: err = (offset > (depth - 32'd2)) || addr[0];
      SZ_W:        err = (offset > (depth - 32'd4)) || (addr[1:0] != 2'b00);
      default:     err = 1'b1;
    endcase
    if (we && size[2]) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_load_extract.sv
// Load data extraction: picks the addressed byte/halfword out of the memory
// word and sign- or zero-extends it to 32 bits according to the size code.
module dmem_load_extract
  import dmem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  size,
  output logic [31:0] value
);

  logic [31:0] shifted_s;

  // Align the addressed lane to bit 0, then extend per size code.
  always_comb begin
    shifted_s = word >> {byte_off, 3'b000};
    case (size)
      SZ_B:    value = {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_BU:   value = {24'd0, shifted_s[7:0]};
      SZ_H:    value = {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_HU:   value = {16'd0, shifted_s[15:0]};
      SZ_W:    value = word;
      default: value = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single byte-addressed data memory.
// Port 0 is the load/store unit, port 1 the debug/DMA port. Each access
// runs IDLE -> ACCESS -> RESP; memory strobes are live only in ACCESS.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise port 0 has fixed priority and no pointer state exists.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] DEPTH_BYTES = 32'd256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [1:0][31:0] addr_i,
  input  logic [1:0][31:0] wdata_i,
  input  logic [1:0][2:0]  size_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_size,
  input  logic [31:0]      mem_rdata
);

  state_t      state_r;
  req_t        lat_r;
  logic        err_r;
  logic [1:0]  rvalid_r;
  logic [31:0] rdata_r;
  logic        resp_err_r;
  logic        any_req_s;
  logic        win_s;
  logic [31:0] ext_s;

`ifdef DMEM_ARB_RR_EN
  logic prio_r;

  // Winner selection: on a tie the port holding priority wins.
  always_comb begin
    any_req_s = |req_i;
    if (req_i[0] && req_i[1]) begin
      win_s = prio_r;
    end else begin
      win_s = req_i[1];
    end
  end

  // Priority passes to the other port every time a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= 1'b0;
    end else if ((state_r == IDLE) && any_req_s) begin
      prio_r <= ~win_s;
    end else begin
      prio_r <= prio_r;
    end
  end
`else
  // Winner selection: port 0 wins whenever it requests.
  always_comb begin
    any_req_s = |req_i;
    if (req_i[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`endif

  // Grant is offered only while idle and out of reset.
  always_comb begin
    if (!reset && (state_r == IDLE) && any_req_s) begin
      gnt_o = win_s ? 2'b10 : 2'b01;
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Memory strobes for a legal access during ACCESS; forced low in reset.
  always_comb begin
    if (!reset && (state_r == ACCESS) && !err_r) begin
      mem_wr_en = lat_r.we;
      mem_rd_en = ~lat_r.we;
      mem_addr  = lat_r.addr;
      mem_wdata = lat_r.wdata;
      mem_size  = {1'b0, lat_r.size[1:0]};
    end else begin
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_size  = 3'd0;
    end
  end

  dmem_load_extract u_extract (
    .word     (mem_rdata),
    .byte_off (lat_r.addr[1:0]),
    .size     (lat_r.size),
    .value    (ext_s)
  );

  // Transaction sequencer: latch the winner, perform the access, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      lat_r      <= '0;
      err_r      <= 1'b0;
      rvalid_r   <= 2'b00;
      rdata_r    <= 32'd0;
      resp_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_r   <= 2'b00;
          rdata_r    <= 32'd0;
          resp_err_r <= 1'b0;
          if (any_req_s) begin
            lat_r   <= '{we: we_i[win_s], addr: addr_i[win_s],
                         wdata: wdata_i[win_s], size: size_i[win_s], id: win_s};
            err_r   <= access_err(we_i[win_s], addr_i[win_s], size_i[win_s],
                                  BASE_ADDR, DEPTH_BYTES);
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          rvalid_r   <= lat_r.id ? 2'b10 : 2'b01;
          rdata_r    <= (err_r || lat_r.we) ? 32'd0 : ext_s;
          resp_err_r <= err_r;
          state_r    <= RESP;
        end
        RESP: begin
          rvalid_r   <= 2'b00;
          rdata_r    <= 32'd0;
          resp_err_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          rvalid_r   <= 2'b00;
          rdata_r    <= 32'd0;
          resp_err_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;
  assign err_o    = resp_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared with a byte-array reference model of the memory.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fill = 1'b1;
  logic [1:0]       req_i = 2'b00;
  logic [1:0]       we_i = 2'b00;
  logic [1:0][31:0] addr_i = '0;
  logic [1:0][31:0] wdata_i = '0;
  logic [1:0][2:0]  size_i = '0;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             mem_wr_en, mem_rd_en;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [2:0]       mem_size;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] moff_s;
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          timeout;
    logic        acc_wr;
    logic        acc_rd;
    logic [31:0] acc_addr;
    logic [1:0]  acc_rv;
    logic [1:0]  rv;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } dir_t;

  always #5 clk = ~clk;

  dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_BYTES(32'd256)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) + 11);
  endfunction

  // Memory: combinational word read at the aligned address.
  always_comb begin
    moff_s = (mem_addr - BASE) & ~32'd3;
    if (moff_s < 32'(DEPTH)) begin
      mem_rdata = {mem[{moff_s[7:2], 2'd3}], mem[{moff_s[7:2], 2'd2}],
                   mem[{moff_s[7:2], 2'd1}], mem[{moff_s[7:2], 2'd0}]};
    end else begin
      mem_rdata = 32'd0;
    end
  end

  // Memory: initial fill, then writes commit on the falling edge.
  always @(negedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if ((k < (1 << mem_size[1:0])) && (int'(mem_addr - BASE) + k < DEPTH))
          mem[int'(mem_addr - BASE) + k] <= 8'(mem_wdata >> (8 * k));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_len(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_err(input bit we, input logic [31:0] addr, input logic [2:0] size);
    int n;
    logic [31:0] off;
    n = ref_len(size);
    off = addr - BASE;
    if (n == 0) return 1'b1;
    if (we && size[2]) return 1'b1;
    if ((longint'(addr) % n) != 0) return 1'b1;
    if (longint'(off) + n > DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size);
    int n;
    int off;
    longint v;
    n = ref_len(size);
    off = int'(addr - BASE);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[off + k]) << (8 * k));
    if (!size[2] && (n < 4) && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
    int off;
    off = int'(addr - BASE);
    for (int k = 0; k < ref_len(size); k++) ref_mem[off + k] = 8'(wdata >> (8 * k));
  endtask

  // ---------------- stimulus driver ----------------
  task automatic drive_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] size, output obs_t o);
    o = '{default: '0};
    @(negedge clk);
    we_i[port] = we; addr_i[port] = addr; wdata_i[port] = wdata; size_i[port] = size;
    req_i[port] = 1'b1;
    o.timeout = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (gnt_o[port]) begin o.timeout = 1'b0; break; end
      @(negedge clk);
    end
    if (o.timeout) begin req_i[port] = 1'b0; return; end
    @(posedge clk); #1;
    req_i[port] = 1'b0;
    @(negedge clk);
    o.acc_wr = mem_wr_en; o.acc_rd = mem_rd_en; o.acc_addr = mem_addr; o.acc_rv = rvalid_o;
    @(negedge clk);
    o.rv = rvalid_o; o.rdata = rdata_o; o.err = err_o;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    req_i = 2'b11; addr_i[0] = BASE; addr_i[1] = BASE;
    #1;
    checks++;
    if ({gnt_o, rvalid_o, rdata_o, err_o, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, mem_size} !== '0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b rdata=%h err=%b wr=%b rd=%b required all zero",
               gnt_o, rvalid_o, rdata_o, err_o, mem_wr_en, mem_rd_en);
    end
    req_i = 2'b00; reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({gnt_o, rvalid_o, rdata_o, err_o, mem_wr_en, mem_rd_en} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset gnt=%b rvalid=%b rdata=%h err=%b required all zero",
               gnt_o, rvalid_o, rdata_o, err_o);
    end
  endtask

  task automatic test_directed();
    dir_t dq[$];
    obs_t o;
    dq.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0013, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0013, 32'h0, 3'b100, 32'h0000_00DE, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0012, 32'h0, 3'b001, 32'hFFFF_DEAD, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0002, 32'h0, 3'b010, 32'h0, 1'b1});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0001, 32'h0, 3'b001, 32'h0, 1'b1});
    dq.push_back('{1'b0, 1'b0, 32'h8000_00FD, 32'h0, 3'b010, 32'h0, 1'b1});
    dq.push_back('{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0, 3'b000, 32'h0, 1'b1});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0});
    dq.push_back('{1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 3'b010, 32'h0, 1'b0});
    dq.push_back('{1'b1, 1'b1, 32'h8000_0020, 32'h0000_005A, 3'b000, 32'h0, 1'b0});
    dq.push_back('{1'b1, 1'b0, 32'h8000_0020, 32'h0, 3'b010, 32'h1122_335A, 1'b0});
    dq.push_back('{1'b1, 1'b1, 32'h8000_0030, 32'h0000_0077, 3'b100, 32'h0, 1'b1});
    dq.push_back('{1'b0, 1'b1, 32'h8000_00FC, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_00FC, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_00FE, 32'h0, 3'b001, 32'hFFFF_CAFE, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_00FF, 32'h0, 3'b000, 32'hFFFF_FFCA, 1'b0});
    dq.push_back('{1'b0, 1'b0, 32'h8000_0100, 32'h0, 3'b100, 32'h0, 1'b1});
    dq.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b011, 32'h0, 1'b1});
    foreach (dq[i]) begin
      drive_txn(dq[i].port, dq[i].we, dq[i].addr, dq[i].wdata, dq[i].size, o);
      checks++;
      if (o.timeout) begin
        failures++;
        $display("FAIL dir%0d_gnt no grant within 20 cycles", i);
        continue;
      end
      checks++;
      if (o.rv !== (dq[i].port ? 2'b10 : 2'b01) || o.acc_rv !== 2'b00) begin
        failures++;
        $display("FAIL dir%0d_rvalid access=%b resp=%b required 00 then port %0d", i, o.acc_rv, o.rv, dq[i].port);
      end
      checks++;
      if (o.rdata !== dq[i].exp_rdata || o.err !== dq[i].exp_err) begin
        failures++;
        $display("FAIL dir%0d_data rdata=%h err=%b required rdata=%h err=%b", i, o.rdata, o.err,
                 dq[i].exp_rdata, dq[i].exp_err);
      end
      checks++;
      if (o.acc_wr !== (!dq[i].exp_err && dq[i].we) || o.acc_rd !== (!dq[i].exp_err && !dq[i].we)) begin
        failures++;
        $display("FAIL dir%0d_strobes wr=%b rd=%b required wr=%b rd=%b", i, o.acc_wr, o.acc_rd,
                 !dq[i].exp_err && dq[i].we, !dq[i].exp_err && !dq[i].we);
      end
      if (!dq[i].exp_err) begin
        checks++;
        if (o.acc_addr !== dq[i].addr) begin
          failures++;
          $display("FAIL dir%0d_mem_addr got=%h required=%h", i, o.acc_addr, dq[i].addr);
        end
        if (dq[i].we) ref_store(dq[i].addr, dq[i].wdata, dq[i].size);
      end
    end
  endtask

  task automatic test_arbitration();
    int grants = 0;
    int cyc = 0;
    int last = -1;
    int exp_w;
    int w;
    apply_reset();
    @(negedge clk);
    we_i = 2'b00; size_i[0] = 3'b010; size_i[1] = 3'b010;
    addr_i[0] = 32'h8000_0010; addr_i[1] = 32'h8000_0020;
    req_i = 2'b11;
    while (grants < 4 && cyc < 40) begin
      #1;
      cyc++;
      if (gnt_o != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
        exp_w = (last < 0) ? 0 : 1 - last;
`else
        exp_w = 0;
`endif
        w = gnt_o[1] ? 1 : 0;
        checks++;
        if (gnt_o !== (exp_w == 1 ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL arb_grant%0d gnt=%b required port %0d", grants, gnt_o, exp_w);
        end
        last = w;
        grants++;
        @(posedge clk); #1;
        if (grants == 4) req_i = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (gnt_o !== 2'b00) begin
          failures++;
          $display("FAIL arb_gnt_in_access gnt=%b required 00", gnt_o);
        end
        @(negedge clk); #1;
        checks++;
        if (gnt_o !== 2'b00 || rvalid_o !== (w == 1 ? 2'b10 : 2'b01) ||
            rdata_o !== ref_load(addr_i[w], 3'b010)) begin
          failures++;
          $display("FAIL arb_resp%0d gnt=%b rvalid=%b rdata=%h required gnt=00 port %0d rdata=%h",
                   grants, gnt_o, rvalid_o, rdata_o, w, ref_load(addr_i[w], 3'b010));
        end
      end
      @(negedge clk);
    end
    req_i = 2'b00;
    checks++;
    if (grants != 4) begin
      failures++;
      $display("FAIL arb_timeout grants=%0d required 4", grants);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    bit got = 1'b0;
    @(negedge clk);
    we_i[0] = 1'b1; addr_i[0] = 32'h8000_0040; wdata_i[0] = 32'h7766_5544; size_i[0] = 3'b010;
    req_i[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (gnt_o[0]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_mid_gnt no grant within 20 cycles");
    end
    @(posedge clk); #1;
    req_i[0] = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_strobes wr=%b rd=%b required 0 0", mem_wr_en, mem_rd_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_o, rvalid_o, rdata_o, err_o, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, mem_size} !== '0) begin
        failures++;
        $display("FAIL rst_mid_outputs c=%0d gnt=%b rvalid=%b rdata=%h err=%b wr=%b required all zero",
                 c, gnt_o, rvalid_o, rdata_o, err_o, mem_wr_en);
      end
    end
    drive_txn(1'b0, 1'b0, 32'h8000_0040, 32'h0, 3'b010, o);
    checks++;
    if (o.timeout || o.rv !== 2'b01 || o.rdata !== ref_load(32'h8000_0040, 3'b010) || o.err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_readback rv=%b rdata=%h err=%b required rv=01 rdata=%h err=0",
               o.rv, o.rdata, o.err, ref_load(32'h8000_0040, 3'b010));
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] sz_tab [8];
    bit port, we, e;
    logic [31:0] addr, wdata, exp_d;
    logic [2:0] size;
    sz_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int t = 0; t < 60; t++) begin
      port  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      size  = sz_tab[$urandom_range(0, 7)];
      wdata = $urandom;
      case ($urandom_range(0, 5))
        0:       addr = $urandom;
        1:       addr = BASE - 32'($urandom_range(1, 4));
        default: addr = BASE + 32'($urandom_range(0, 259));
      endcase
      e = ref_err(we, addr, size);
      exp_d = (e || we) ? 32'd0 : ref_load(addr, size);
      drive_txn(port, we, addr, wdata, size, o);
      checks++;
      if (o.timeout || o.rv !== (port ? 2'b10 : 2'b01) || o.rdata !== exp_d || o.err !== e) begin
        failures++;
        $display("FAIL rnd%0d p=%0d we=%0d a=%h sz=%b rv=%b rdata=%h err=%b required rdata=%h err=%b",
                 t, port, we, addr, size, o.rv, o.rdata, o.err, exp_d, e);
      end
      checks++;
      if (o.acc_wr !== (!e && we) || o.acc_rd !== (!e && !we)) begin
        failures++;
        $display("FAIL rnd%0d_strobes wr=%b rd=%b required wr=%b rd=%b", t, o.acc_wr, o.acc_rd,
                 !e && we, !e && !we);
      end
      if (!e && we) ref_store(addr, wdata, size);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clk);
    fill = 1'b0;
    test_reset();
    test_directed();
    test_arbitration();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
